veri_dsm_sinc3_dec_4to15: RTL and testbench

//   Receive-side decimator for the order-2 4-bit delta-sigma stream. Accepts the

---
 rtl/veri_dsm_sinc3_dec_4to15.sv | 92 +++++++++
 tb/tb_veri_dsm_sinc3_dec_4to15.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/veri_dsm_sinc3_dec_4to15.sv
// Third-order CIC (sinc^3) decimator for the 4-bit offset-binary delta-sigma stream.
// Decimates by 2**DEC_LOG2 and emits a 15-bit offset-binary word with a one-clock strobe.
module veri_dsm_sinc3_dec_4to15 #(
  parameter int DEC_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  din,
  input  logic        din_valid,
  output logic [14:0] dout,
  output logic        dout_valid,
  output logic        settled
);

  localparam int ACC_W = 4 + 3 * DEC_LOG2;
  localparam logic [DEC_LOG2-1:0] PHASE_LAST = {DEC_LOG2{1'b1}};
  localparam logic [DEC_LOG2-1:0] PHASE_ONE  = {{(DEC_LOG2-1){1'b0}}, 1'b1};

  logic [ACC_W-1:0]    i1_r, i2_r, i3_r;
  logic [ACC_W-1:0]    c0_r, d1_r, d2_r, d3_r;
  logic [DEC_LOG2-1:0] phase_r;
  logic                tick_r;
  logic [1:0]          out_cnt_r;
  logic [14:0]         dout_r;
  logic                dout_valid_r;
  logic                settled_r;

  logic [3:0]          x4_s;
  logic [ACC_W-1:0]    x_s;
  logic [ACC_W-1:0]    y1_s, y2_s, y3_s;
  logic [14:0]         s_s;

  // Input mapping to signed and the comb differences of the captured sample.
  always_comb begin
    x4_s = {~din[3], din[2:0]};
    x_s  = {{(ACC_W-4){x4_s[3]}}, x4_s};
    y1_s = c0_r - d1_r;
    y2_s = y1_s - d2_r;
    y3_s = y2_s - d3_r;
    s_s  = y3_s[ACC_W-1 -: 15];
  end

  // Integrators, decimation phase, comb delays and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i1_r         <= '0;
      i2_r         <= '0;
      i3_r         <= '0;
      c0_r         <= '0;
      d1_r         <= '0;
      d2_r         <= '0;
      d3_r         <= '0;
      phase_r      <= '0;
      tick_r       <= 1'b0;
      out_cnt_r    <= 2'd0;
      dout_r       <= 15'h4000;
      dout_valid_r <= 1'b0;
      settled_r    <= 1'b0;
    end else begin
      if (din_valid) begin
        i1_r    <= i1_r + x_s;
        i2_r    <= i2_r + i1_r;
        i3_r    <= i3_r + i2_r;
        phase_r <= phase_r + PHASE_ONE;
        // Capture the pre-update integrator value on the last sample of a frame.
        if (phase_r == PHASE_LAST) begin
          c0_r <= i3_r;
        end
      end
      tick_r       <= din_valid && (phase_r == PHASE_LAST);
      dout_valid_r <= tick_r;
      // Comb runs one edge after the tick, independent of din_valid on that edge.
      if (tick_r) begin
        d1_r   <= c0_r;
        d2_r   <= y1_s;
        d3_r   <= y2_s;
        dout_r <= {~s_s[14], s_s[13:0]};
        if (out_cnt_r != 2'd3) begin
          out_cnt_r <= out_cnt_r + 2'd1;
        end
        if (out_cnt_r == 2'd2) begin
          settled_r <= 1'b1;
        end
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign settled    = settled_r;

endmodule

// File: tb/tb_veri_dsm_sinc3_dec_4to15.sv
// Randomized bench for the sinc^3 decimator; the reference computes each frame's
// integrator value as a binomially weighted sum of past samples in unbounded integers.
module tb_veri_dsm_sinc3_dec_4to15;

  localparam int R = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din;
  logic        din_valid;
  logic [14:0] dout;
  logic        dout_valid;
  logic        settled;

  int tests_run = 0;
  int failed    = 0;

  // reference model state
  int     hist[$];
  longint c0q[$];
  int     n_acc;
  int     n_out;
  bit     pend;
  logic        exp_valid;
  logic [14:0] exp_dout;
  logic        exp_settled;

  veri_dsm_sinc3_dec_4to15 #(.DEC_LOG2(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  // Third running sum after n samples: sum of x_m * C(n-1-m, 2).
  function automatic longint third_sum(input int n);
    longint acc = 0;
    for (int m = 0; m < n; m++) begin
      longint a = n - 1 - m;
      acc += longint'(hist[m]) * a * (a - 1) / 2;
    end
    return acc;
  endfunction

  function automatic longint c0_of(input int k);
    if (k < 1) return 0;
    return c0q[k-1];
  endfunction

  function automatic logic [14:0] frame_word(input int k);
    longint y;
    logic [63:0] yb;
    logic [14:0] s;
    y  = c0_of(k) - 3 * c0_of(k-1) + 3 * c0_of(k-2) - c0_of(k-3);
    yb = y;
    s  = yb[15:1];
    return s ^ 15'h4000;
  endfunction

  task automatic model_reset();
    hist.delete();
    c0q.delete();
    n_acc = 0;
    n_out = 0;
    pend = 1'b0;
    exp_valid = 1'b0;
    exp_dout = 15'h4000;
    exp_settled = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_cycle(input logic [3:0] d, input logic v);
    din = d;
    din_valid = v;
    @(posedge clk);
    exp_valid = pend;
    if (pend) begin
      c0q.push_back(third_sum(n_acc - 1));
      n_out++;
      exp_dout = frame_word(n_out);
      if (n_out >= 3) exp_settled = 1'b1;
    end
    pend = 1'b0;
    if (v) begin
      hist.push_back(int'(d) - 8);
      n_acc++;
      if (n_acc % R == 0) pend = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    din = 4'($urandom);
    din_valid = 1'b1;
    do_reset();
    tests_run++;
    if (dout !== 15'h4000) begin failed++; $display("FAIL reset_dout got=%h exp=4000", dout); end
    tests_run++;
    if (dout_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    tests_run++;
    if (settled !== 1'b0) begin failed++; $display("FAIL reset_settled got=%b exp=0", settled); end
  endtask

  task automatic test_zero();
    int strobes = 0;
    int last_cyc = 0;
    do_reset();
    for (int c = 1; c <= 4 * R + 2; c++) begin
      drive_cycle(4'd8, 1'b1);
      tests_run++;
      if (dout_valid !== exp_valid) begin failed++; $display("FAIL zero_valid cyc=%0d got=%b exp=%b", c, dout_valid, exp_valid); end
      tests_run++;
      if (dout !== 15'h4000) begin failed++; $display("FAIL zero_dout cyc=%0d got=%h exp=4000", c, dout); end
      tests_run++;
      if (settled !== exp_settled) begin failed++; $display("FAIL zero_settled cyc=%0d got=%b exp=%b", c, settled, exp_settled); end
      if (dout_valid === 1'b1) begin
        strobes++;
        tests_run++;
        if (c != (strobes == 1 ? R + 1 : last_cyc + R)) begin
          failed++; $display("FAIL zero_spacing strobe=%0d cyc=%0d last=%0d", strobes, c, last_cyc);
        end
        tests_run++;
        if (settled !== (strobes >= 3)) begin failed++; $display("FAIL zero_settle_rise strobe=%0d got=%b", strobes, settled); end
        last_cyc = c;
      end
    end
    tests_run++;
    if (strobes != 4) begin failed++; $display("FAIL zero_count got=%0d exp=4", strobes); end
  endtask

  task automatic test_dc_plus4();
    do_reset();
    for (int c = 1; c <= 6 * R + 2; c++) begin
      drive_cycle(4'd12, 1'b1);
      tests_run++;
      if (dout_valid !== exp_valid) begin failed++; $display("FAIL dc4_valid cyc=%0d got=%b exp=%b", c, dout_valid, exp_valid); end
      if (exp_valid) begin
        tests_run++;
        if (dout !== exp_dout) begin failed++; $display("FAIL dc4_dout out=%0d got=%h exp=%h", n_out, dout, exp_dout); end
        tests_run++;
        if (n_out <= 2 && !(dout < 15'h6000)) begin failed++; $display("FAIL dc4_transient out=%0d got=%h", n_out, dout); end
        else if (n_out >= 4 && dout !== 15'h6000) begin failed++; $display("FAIL dc4_settled out=%0d got=%h exp=6000", n_out, dout); end
      end
    end
  endtask

  task automatic test_full_scale();
    logic [3:0]  codes [2];
    logic [14:0] want  [2];
    codes[0] = 4'd0;  want[0] = 15'h0000;
    codes[1] = 4'd15; want[1] = 15'h7800;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      for (int c = 1; c <= 1000 * R + 2; c++) begin
        drive_cycle(codes[t], 1'b1);
        if (exp_valid) begin
          tests_run++;
          if (dout !== exp_dout) begin failed++; $display("FAIL fs_dout code=%0d out=%0d got=%h exp=%h", codes[t], n_out, dout, exp_dout); end
          if (n_out >= 4) begin
            tests_run++;
            if (dout !== want[t]) begin failed++; $display("FAIL fs_drift code=%0d out=%0d got=%h exp=%h", codes[t], n_out, dout, want[t]); end
          end
        end
        tests_run++;
        if (dout_valid !== exp_valid) begin failed++; $display("FAIL fs_valid code=%0d cyc=%0d got=%b exp=%b", codes[t], c, dout_valid, exp_valid); end
      end
    end
  endtask

  task automatic test_valid_toggle();
    do_reset();
    for (int c = 1; c <= 40 * R; c++) begin
      drive_cycle(4'd12, 1'($urandom));
      tests_run++;
      if (dout_valid !== exp_valid) begin failed++; $display("FAIL tog_valid cyc=%0d got=%b exp=%b", c, dout_valid, exp_valid); end
      if (exp_valid) begin
        tests_run++;
        if (dout !== exp_dout) begin failed++; $display("FAIL tog_dout out=%0d got=%h exp=%h", n_out, dout, exp_dout); end
        if (n_out >= 4) begin
          tests_run++;
          if (dout !== 15'h6000) begin failed++; $display("FAIL tog_settled out=%0d got=%h exp=6000", n_out, dout); end
        end
      end else begin
        tests_run++;
        if (dout !== exp_dout) begin failed++; $display("FAIL tog_hold cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 1; c <= 60 * R; c++) begin
      drive_cycle(4'($urandom), ($urandom_range(0, 3) != 0));
      tests_run++;
      if (dout_valid !== exp_valid) begin failed++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, dout_valid, exp_valid); end
      tests_run++;
      if (dout !== exp_dout) begin failed++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
      tests_run++;
      if (settled !== exp_settled) begin failed++; $display("FAIL rnd_settled cyc=%0d got=%b exp=%b", c, settled, exp_settled); end
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    do_reset();
    for (int c = 1; c <= 4 * R + 9; c++) drive_cycle(4'($urandom), 1'b1);
    din_valid = 1'b1;
    do_reset();
    tests_run++;
    if (dout !== 15'h4000) begin failed++; $display("FAIL mid_dout got=%h exp=4000", dout); end
    tests_run++;
    if (dout_valid !== 1'b0) begin failed++; $display("FAIL mid_valid got=%b exp=0", dout_valid); end
    tests_run++;
    if (settled !== 1'b0) begin failed++; $display("FAIL mid_settled got=%b exp=0", settled); end
    seen = 0;
    for (int c = 1; c <= 3 * R && seen == 0; c++) begin
      drive_cycle(4'($urandom), 1'b1);
      if (dout_valid === 1'b1) seen = c;
      tests_run++;
      if (dout !== exp_dout) begin failed++; $display("FAIL mid_out cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
    end
    tests_run++;
    if (seen != R + 1) begin failed++; $display("FAIL mid_first_strobe got_cyc=%0d exp_cyc=%0d", seen, R + 1); end
  endtask

  initial begin
    rst = 1'b0;
    din = 4'd8;
    din_valid = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_zero();
    test_dc_plus4();
    test_full_scale();
    test_valid_toggle();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
